// File: rtl/picture_reader.sv
// VGA 640x480 frame reader: scans the image memory, forwards pixels through the
// processor core and re-aligns the returned colour with delayed sync signals.
`timescale 1ns/1ps
module picture_reader #(
    parameter int MEM_LAT  = 1,
    parameter int PROC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mode_req,
    input  logic [11:0] mem_data,
    input  logic [11:0] ripe_color,
    output logic [18:0] picture_addr,
    output logic [11:0] raw_color,
    output logic [3:0]  state_info,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] vga_rgb,
    output logic        frame_start
);
    localparam int TOTAL = MEM_LAT + PROC_LAT + 2;

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] HS_BEG   = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] VS_BEG   = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [18:0] addr_cnt_q, addr_cnt_d;
    logic [3:0]  state_q, state_d;
    logic [11:0] raw_q, rgb_q;
    logic        fs_q;
    logic        h_wrap, f_wrap, active, hs_raw, vs_raw, mode_ok;
    logic [TOTAL:1] hs_pipe_q, vs_pipe_q, act_pipe_q;

    assign h_wrap  = (h_cnt_q == H_LAST);
    assign f_wrap  = h_wrap && (v_cnt_q == V_LAST);
    assign active  = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
    assign hs_raw  = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    assign vs_raw  = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    assign mode_ok = (mode_req >= 4'd1) && (mode_req <= 4'd6);

    // Linear address is tracked incrementally; it equals v*640+h in every active cycle.
    always_comb begin
        h_cnt_d    = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d    = v_cnt_q;
        addr_cnt_d = addr_cnt_q;
        state_d    = state_q;
        if (h_wrap)
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        if (f_wrap) begin
            addr_cnt_d = '0;
            state_d    = mode_ok ? mode_req : 4'd1;
        end else if (active) begin
            addr_cnt_d = addr_cnt_q + 19'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            addr_cnt_q <= '0;
            state_q    <= 4'd1;
            raw_q      <= '0;
            rgb_q      <= '0;
            fs_q       <= 1'b0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            act_pipe_q <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            state_q    <= state_d;
            raw_q      <= mem_data;
            fs_q       <= f_wrap;
            hs_pipe_q  <= {hs_pipe_q[TOTAL-1:1], hs_raw};
            vs_pipe_q  <= {vs_pipe_q[TOTAL-1:1], vs_raw};
            act_pipe_q <= {act_pipe_q[TOTAL-1:1], active};
            // Gated by stage TOTAL-1 so the colour register lands with stage TOTAL syncs.
            rgb_q      <= act_pipe_q[TOTAL-1] ? ripe_color : 12'd0;
        end
    end

    assign picture_addr = active ? addr_cnt_q : 19'd0;
    assign raw_color    = raw_q;
    assign state_info   = state_q;
    assign hsync        = hs_pipe_q[TOTAL];
    assign vsync        = vs_pipe_q[TOTAL];
    assign vga_rgb      = rgb_q;
    assign frame_start  = fs_q;
endmodule

// File: tb/tb_picture_reader.sv
// Bench for picture_reader with a 1-cycle memory model and a 1-cycle processor model.
`timescale 1ns/1ps
module tb_picture_reader;
    localparam int TOTAL = 4;
    localparam int FRAME = 420000;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mode_req = 4'd0;
    logic [11:0] mem_data, ripe_color;
    logic [18:0] picture_addr;
    logic [11:0] raw_color, vga_rgb;
    logic [3:0]  state_info;
    logic        hsync, vsync, frame_start;
    logic [11:0] mem_q, ripe_q;

    int checks = 0;
    int errors = 0;
    int cyc;
    exp_t q[$];

    picture_reader #(.MEM_LAT(1), .PROC_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .mode_req(mode_req), .mem_data(mem_data),
        .ripe_color(ripe_color), .picture_addr(picture_addr), .raw_color(raw_color),
        .state_info(state_info), .hsync(hsync), .vsync(vsync), .vga_rgb(vga_rgb),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Memory returns the low 12 address bits one cycle later; processor is a 1-cycle pass-through.
    always @(posedge clk) begin
        mem_q  <= picture_addr[11:0];
        ripe_q <= raw_color;
    end
    assign mem_data   = mem_q;
    assign ripe_color = ripe_q;

    // Edges since reset release; the counters of the DUT follow from this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int cur_h();
        return (cyc % FRAME) % 800;
    endfunction

    function automatic int cur_v();
        return (cyc % FRAME) / 800;
    endfunction

    task automatic goto(input int h, input int v);
        int n = 0;
        while ((cyc % FRAME) != v * 800 + h && n <= FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n > FRAME) begin
            checks++; errors++;
            $display("FAIL goto(%0d,%0d): position never reached", h, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (picture_addr !== 19'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", picture_addr); end
        if (raw_color !== 12'd0) begin errors++; $display("FAIL reset_raw: got %h want 000", raw_color); end
        if (state_info !== 4'd1) begin errors++; $display("FAIL reset_state: got %b want 0001", state_info); end
        if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        if (vga_rgb !== 12'd0) begin errors++; $display("FAIL reset_rgb: got %h want 000", vga_rgb); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL first_fs: got %b want 0", frame_start); end
        if (picture_addr !== 19'd2) begin errors++; $display("FAIL resume_addr: got %0d want 2", picture_addr); end
    endtask

    task automatic test_address();
        goto(640, 0);
        checks++;
        if (picture_addr !== 19'd0) begin errors++; $display("FAIL addr_640_0: got %0d want 0", picture_addr); end
    endtask

    task automatic test_datapath();
        exp_t e;
        int h, v, a;
        goto(700, 0);
        q.delete();
        for (int n = 0; n < 2600; n++) begin
            h = cur_h();
            v = cur_v();
            if (q.size() == TOTAL) begin
                e = q.pop_front();
                checks += 3;
                if (vga_rgb !== e.rgb) begin errors++; $display("FAIL sb_rgb (%0d,%0d): got %h want %h", h, v, vga_rgb, e.rgb); end
                if (hsync !== e.hs) begin errors++; $display("FAIL sb_hsync (%0d,%0d): got %b want %b", h, v, hsync, e.hs); end
                if (vsync !== e.vs) begin errors++; $display("FAIL sb_vsync (%0d,%0d): got %b want %b", h, v, vsync, e.vs); end
            end
            a = v * 640 + h;
            e.rgb = (h < 640 && v < 480) ? a[11:0] : 12'd0;
            e.hs  = !(h >= 656 && h <= 751);
            e.vs  = !(v >= 490 && v <= 491);
            q.push_back(e);
            if (h == 5 && v == 2) begin
                checks++;
                if (picture_addr !== 19'd1285) begin errors++; $display("FAIL addr_5_2: got %0d want 1285", picture_addr); end
            end
            if (h == 9 && v == 2) begin
                checks++;
                if (vga_rgb !== 12'h505) begin errors++; $display("FAIL rgb_5_2: got %h want 505", vga_rgb); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hsync();
        int n = 0, lo = 0, p;
        goto(656, 10);
        while (hsync !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        while (hsync === 1'b0 && lo < 1000) begin @(negedge clk); lo++; end
        p = lo;
        while (hsync !== 1'b0 && p < 2000) begin @(negedge clk); p++; end
        checks += 3;
        if (n != 4) begin errors++; $display("FAIL hsync_delay: got %0d want 4", n); end
        if (lo != 96) begin errors++; $display("FAIL hsync_width: got %0d want 96", lo); end
        if (p != 800) begin errors++; $display("FAIL hsync_period: got %0d want 800", p); end
    endtask

    task automatic test_mode_latch_begin();
        goto(0, 100);
        mode_req = 4'b0010;
        @(negedge clk);
        checks++;
        if (state_info !== 4'd1) begin errors++; $display("FAIL mode_early: got %b want 0001", state_info); end
    endtask

    task automatic test_addr_corner();
        goto(639, 479);
        checks++;
        if (picture_addr !== 19'd307199) begin errors++; $display("FAIL addr_639_479: got %0d want 307199", picture_addr); end
    endtask

    task automatic test_mode_latch_wrap();
        goto(799, 524);
        checks += 2;
        if (state_info !== 4'd1) begin errors++; $display("FAIL mode_prewrap: got %b want 0001", state_info); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_prewrap: got %b want 0", frame_start); end
        @(negedge clk);
        checks += 2;
        if (state_info !== 4'b0010) begin errors++; $display("FAIL mode_wrap: got %b want 0010", state_info); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_wrap: got %b want 1", frame_start); end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_pulse: got %b want 0", frame_start); end
    endtask

    task automatic test_frame_illegal_mode();
        int lo = 0, fs = 0;
        mode_req = 4'b1001;
        for (int n = 0; n < FRAME - 1; n++) begin
            @(negedge clk);
            if (vsync === 1'b0) lo++;
            if (frame_start === 1'b1) fs++;
            if ((cyc % FRAME) == FRAME - 1) begin
                checks++;
                if (state_info !== 4'b0010) begin errors++; $display("FAIL mode_hold: got %b want 0010", state_info); end
            end
        end
        checks += 4;
        if (lo != 1600) begin errors++; $display("FAIL vsync_low: got %0d want 1600", lo); end
        if (fs != 1) begin errors++; $display("FAIL fs_count: got %0d want 1", fs); end
        if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_frame2: got %b want 1", frame_start); end
        if (state_info !== 4'd1) begin errors++; $display("FAIL mode_illegal: got %b want 0001", state_info); end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        goto(700, 200);
        checks++;
        if (hsync !== 1'b0) begin errors++; $display("FAIL mid_hsync_pre: got %b want 0", hsync); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (hsync !== 1'b1) begin errors++; $display("FAIL mid_hsync: got %b want 1", hsync); end
        if (vsync !== 1'b1) begin errors++; $display("FAIL mid_vsync: got %b want 1", vsync); end
        if (vga_rgb !== 12'd0) begin errors++; $display("FAIL mid_rgb: got %h want 000", vga_rgb); end
        if (state_info !== 4'd1) begin errors++; $display("FAIL mid_state: got %b want 0001", state_info); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs: got %b want 0", frame_start); end
        mode_req = 4'b0011;
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (picture_addr !== 19'd0) begin errors++; $display("FAIL mid_addr: got %0d want 0", picture_addr); end
        while (frame_start !== 1'b1 && n <= FRAME + 10) begin @(negedge clk); n++; end
        checks += 2;
        if (n != FRAME) begin errors++; $display("FAIL mid_fs_delay: got %0d want %0d", n, FRAME); end
        if (state_info !== 4'b0011) begin errors++; $display("FAIL mid_mode: got %b want 0011", state_info); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_address();
        test_datapath();
        test_hsync();
        test_mode_latch_begin();
        test_addr_corner();
        test_mode_latch_wrap();
        test_frame_illegal_mode();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
